// File: rtl/writeback_scoreboard.sv
// Writeback scoreboard: tracks outstanding register writes from decode
// so that hazards on source operands can be detected. Each tracked
// register keeps a 2-bit pending count. A global in-flight count caps the
// total number of outstanding writes.
module writeback_scoreboard #(
   parameter int REGISTER_INDEX_WIDTH = 5,
   parameter int NUM_REGS             = 32,
   parameter int MAX_INFLIGHT         = 7
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            issue_valid,
   input  logic [REGISTER_INDEX_WIDTH-1:0] issue_idx_dst,
   output logic                            issue_ready,
   input  logic                            alu_wb_valid,
   input  logic [REGISTER_INDEX_WIDTH-1:0] alu_wb_idx,
   input  logic                            mem_wb_valid,
   input  logic [REGISTER_INDEX_WIDTH-1:0] mem_wb_idx,
   input  logic                            flush,
   input  logic [REGISTER_INDEX_WIDTH-1:0] query_idx_src_1,
   input  logic [REGISTER_INDEX_WIDTH-1:0] query_idx_src_2,
   output logic                            src_1_pending,
   output logic                            src_2_pending,
   output logic [2:0]                      inflight_count,
   output logic                            underflow_error
);

   localparam int W = REGISTER_INDEX_WIDTH;
   typedef logic [W-1:0] idx_t;

   // Indices beyond the register file alias to register 0, which is untracked.
   function automatic idx_t map_idx(input idx_t idx);
      logic [31:0] ext;
      ext = 32'(idx);
      if (ext < 32'(NUM_REGS)) begin
         map_idx = idx;
      end else begin
         map_idx = {W{1'b0}};
      end
   endfunction

   logic [1:0] cnt_q [NUM_REGS];
   logic [1:0] cnt_d [NUM_REGS];
   logic [2:0] inflight_q;
   logic [2:0] inflight_d;
   logic       underflow_q;
   logic       underflow_d;

   idx_t       iss_m_s;
   idx_t       alu_m_s;
   idx_t       mem_m_s;
   idx_t       q1_m_s;
   idx_t       q2_m_s;
   logic       iss_acc_s;
   logic       alu_hit_s;
   logic       alu_dec_s;
   logic       mem_hit_s;
   logic       mem_dec_s;
   logic [1:0] mem_base_s;

   // Decode side: admission control, writeback qualification and source queries.
   always_comb begin
      iss_m_s     = map_idx(issue_idx_dst);
      alu_m_s     = map_idx(alu_wb_idx);
      mem_m_s     = map_idx(mem_wb_idx);
      q1_m_s      = map_idx(query_idx_src_1);
      q2_m_s      = map_idx(query_idx_src_2);

      // Register 0 never saturates, so only the global cap can stall it.
      issue_ready = 1'b1;
      if (inflight_q == 3'(MAX_INFLIGHT)) begin
         issue_ready = 1'b0;
      end else if ((iss_m_s != {W{1'b0}}) && (cnt_q[iss_m_s] == 2'd3)) begin
         issue_ready = 1'b0;
      end else begin
         issue_ready = 1'b1;
      end
      iss_acc_s   = issue_valid && issue_ready && (iss_m_s != {W{1'b0}});

      // ALU writeback is retired first; the load writeback sees its effect.
      alu_hit_s   = alu_wb_valid && (alu_m_s != {W{1'b0}});
      alu_dec_s   = alu_hit_s && (cnt_q[alu_m_s] != 2'd0);
      mem_hit_s   = mem_wb_valid && (mem_m_s != {W{1'b0}});
      if (alu_dec_s && (alu_m_s == mem_m_s)) begin
         mem_base_s = cnt_q[mem_m_s] - 2'd1;
      end else begin
         mem_base_s = cnt_q[mem_m_s];
      end
      mem_dec_s   = mem_hit_s && (mem_base_s != 2'd0);

      // Queries look only at registered state; no same-cycle bypass.
      src_1_pending = (q1_m_s != {W{1'b0}}) && (cnt_q[q1_m_s] != 2'd0);
      src_2_pending = (q2_m_s != {W{1'b0}}) && (cnt_q[q2_m_s] != 2'd0);
   end

   // Next-state: flush wins; otherwise apply the net of issue and writebacks.
   always_comb begin
      cnt_d       = cnt_q;
      inflight_d  = inflight_q;
      underflow_d = underflow_q;
      if (flush) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = 2'd0;
         end
         inflight_d = 3'd0;
      end else begin
         cnt_d[0] = 2'd0;
         for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r]
                     + {1'b0, (iss_acc_s && (iss_m_s == idx_t'(r)))}
                     - {1'b0, (alu_dec_s && (alu_m_s == idx_t'(r)))}
                     - {1'b0, (mem_dec_s && (mem_m_s == idx_t'(r)))};
         end
         inflight_d  = inflight_q + {2'b00, iss_acc_s}
                     - {2'b00, alu_dec_s} - {2'b00, mem_dec_s};
         underflow_d = underflow_q | (alu_hit_s & ~alu_dec_s)
                     | (mem_hit_s & ~mem_dec_s);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= 2'd0;
         end
         inflight_q  <= 3'd0;
         underflow_q <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         inflight_q  <= inflight_d;
         underflow_q <= underflow_d;
      end
   end

   assign inflight_count  = inflight_q;
   assign underflow_error = underflow_q;

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Self-checking bench for writeback_scoreboard: a table of hand-computed
// vectors plus a few hand-written reset/flush/fill sequences.
module tb_writeback_scoreboard;

   logic       clk;
   logic       rst_n;
   logic       issue_valid;
   logic [4:0] issue_idx_dst;
   logic       issue_ready;
   logic       alu_wb_valid;
   logic [4:0] alu_wb_idx;
   logic       mem_wb_valid;
   logic [4:0] mem_wb_idx;
   logic       flush;
   logic [4:0] query_idx_src_1;
   logic [4:0] query_idx_src_2;
   logic       src_1_pending;
   logic       src_2_pending;
   logic [2:0] inflight_count;
   logic       underflow_error;

   writeback_scoreboard #(
      .REGISTER_INDEX_WIDTH(5),
      .NUM_REGS(32),
      .MAX_INFLIGHT(7)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .issue_valid(issue_valid),
      .issue_idx_dst(issue_idx_dst),
      .issue_ready(issue_ready),
      .alu_wb_valid(alu_wb_valid),
      .alu_wb_idx(alu_wb_idx),
      .mem_wb_valid(mem_wb_valid),
      .mem_wb_idx(mem_wb_idx),
      .flush(flush),
      .query_idx_src_1(query_idx_src_1),
      .query_idx_src_2(query_idx_src_2),
      .src_1_pending(src_1_pending),
      .src_2_pending(src_2_pending),
      .inflight_count(inflight_count),
      .underflow_error(underflow_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs, pre-edge combinational expectations, post-edge state expectations.
   typedef struct {
      logic       iv;
      logic [4:0] ii;
      logic       av;
      logic [4:0] ai;
      logic       mv;
      logic [4:0] mi;
      logic       fl;
      logic [4:0] q1;
      logic [4:0] q2;
      logic       er;
      logic       ep1;
      logic       ep2;
      logic [2:0] einf;
      logic       eunf;
   } vec_t;

   typedef struct {
      logic [2:0] inf;
      logic       unf;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   vec_t tbl [25];

   function automatic vec_t mkv(input int iv, input int ii, input int av, input int ai,
                                input int mv, input int mi, input int fl,
                                input int q1, input int q2, input int er,
                                input int ep1, input int ep2, input int einf,
                                input int eunf);
      vec_t v;
      v.iv = iv[0];   v.ii = ii[4:0];
      v.av = av[0];   v.ai = ai[4:0];
      v.mv = mv[0];   v.mi = mi[4:0];
      v.fl = fl[0];
      v.q1 = q1[4:0]; v.q2 = q2[4:0];
      v.er = er[0];   v.ep1 = ep1[0]; v.ep2 = ep2[0];
      v.einf = einf[2:0]; v.eunf = eunf[0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      issue_valid = 1'b0; issue_idx_dst = 5'd0;
      alu_wb_valid = 1'b0; alu_wb_idx = 5'd0;
      mem_wb_valid = 1'b0; mem_wb_idx = 5'd0;
      flush = 1'b0;
      query_idx_src_1 = 5'd0; query_idx_src_2 = 5'd0;
   endtask

   // Drive one cycle: check combinational outputs before the edge, state after.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      issue_valid = v.iv; issue_idx_dst = v.ii;
      alu_wb_valid = v.av; alu_wb_idx = v.ai;
      mem_wb_valid = v.mv; mem_wb_idx = v.mi;
      flush = v.fl;
      query_idx_src_1 = v.q1; query_idx_src_2 = v.q2;
      #1;
      chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(v.er));
      chk({tag, ".src_1_pending"}, 32'(src_1_pending), 32'(v.ep1));
      chk({tag, ".src_2_pending"}, 32'(src_2_pending), 32'(v.ep2));
      e.inf = v.einf;
      e.unf = v.eunf;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s.scoreboard: got empty queue expected entry", tag);
      end else begin
         e = sbq.pop_front();
         chk({tag, ".inflight_count"}, 32'(inflight_count), 32'(e.inf));
         chk({tag, ".underflow_error"}, 32'(underflow_error), 32'(e.unf));
      end
   endtask

   // Asynchronous reset pulse, checked before any clock edge.
   task automatic reset_pulse(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      #1;
      chk({tag, ".inflight_count"}, 32'(inflight_count), 32'd0);
      chk({tag, ".underflow_error"}, 32'(underflow_error), 32'd0);
      chk({tag, ".issue_ready"}, 32'(issue_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      //             iv ii av ai mv mi fl q1 q2  er p1 p2 inf unf
      tbl[0]  = mkv(1, 5, 0, 0, 0, 0, 0, 5, 0,  1, 0, 0, 1, 0);
      tbl[1]  = mkv(0, 0, 1, 5, 0, 0, 0, 5, 0,  1, 1, 0, 0, 0);
      tbl[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 5, 0,  1, 0, 0, 0, 0);
      tbl[3]  = mkv(1, 7, 0, 0, 0, 0, 0, 7, 0,  1, 0, 0, 1, 0);
      tbl[4]  = mkv(1, 7, 0, 0, 0, 0, 0, 7, 0,  1, 1, 0, 2, 0);
      tbl[5]  = mkv(1, 7, 0, 0, 0, 0, 0, 7, 0,  1, 1, 0, 3, 0);
      tbl[6]  = mkv(1, 7, 0, 0, 0, 0, 0, 7, 0,  0, 1, 0, 3, 0);
      tbl[7]  = mkv(0, 8, 0, 0, 0, 0, 0, 8, 7,  1, 0, 1, 3, 0);
      tbl[8]  = mkv(0, 0, 1, 7, 1, 7, 0, 7, 0,  1, 1, 0, 1, 0);
      tbl[9]  = mkv(0, 0, 1, 7, 0, 0, 0, 7, 0,  1, 1, 0, 0, 0);
      tbl[10] = mkv(1, 9, 0, 0, 0, 0, 0, 9, 0,  1, 0, 0, 1, 0);
      tbl[11] = mkv(1, 9, 0, 0, 0, 0, 0, 9, 0,  1, 1, 0, 2, 0);
      tbl[12] = mkv(1, 9, 1, 9, 1, 9, 0, 9, 0,  1, 1, 0, 1, 0);
      tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 9, 9,  1, 1, 1, 1, 0);
      tbl[14] = mkv(0, 0, 1, 9, 0, 0, 0, 9, 0,  1, 1, 0, 0, 0);
      tbl[15] = mkv(0, 0, 0, 0, 0, 0, 0, 9, 0,  1, 0, 0, 0, 0);
      tbl[16] = mkv(1, 3, 0, 0, 0, 0, 0, 3, 0,  1, 0, 0, 1, 0);
      tbl[17] = mkv(1, 3, 1, 3, 0, 0, 0, 3, 0,  1, 1, 0, 1, 0);
      tbl[18] = mkv(0, 0, 1, 3, 0, 0, 0, 3, 0,  1, 1, 0, 0, 0);
      tbl[19] = mkv(0, 0, 0, 0, 0, 0, 0, 3, 0,  1, 0, 0, 0, 0);
      tbl[20] = mkv(0, 0, 1, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      tbl[21] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      tbl[22] = mkv(1, 6, 0, 0, 0, 0, 0, 6, 0,  1, 0, 0, 1, 0);
      tbl[23] = mkv(0, 0, 1, 6, 1, 6, 0, 6, 0,  1, 1, 0, 0, 1);
      tbl[24] = mkv(1, 6, 0, 0, 0, 0, 1, 6, 0,  1, 0, 0, 0, 1);

      rst_n = 1'b0;
      clear_inputs();
      #2;
      chk("reset.inflight_count", 32'(inflight_count), 32'd0);
      chk("reset.underflow_error", 32'(underflow_error), 32'd0);
      chk("reset.issue_ready", 32'(issue_ready), 32'd1);
      chk("reset.src_1_pending", 32'(src_1_pending), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 25; i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // Sticky underflow: only reset clears it.
      reset_pulse("rst_a");
      apply(mkv(1, 2, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1, 0), "uf_issue");
      apply(mkv(0, 0, 0, 0, 1, 4, 0, 4, 0, 1, 0, 0, 1, 1), "uf_memwb4");
      apply(mkv(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 1, 0, 0, 1), "uf_flush");
      apply(mkv(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 1), "uf_hold");
      reset_pulse("rst_b");

      // Fill to the in-flight cap across distinct registers, then flush.
      for (int r = 1; r <= 7; r++) begin
         apply(mkv(1, r, 0, 0, 0, 0, 0, r, 0, 1, 0, 0, r, 0), $sformatf("fill%0d", r));
      end
      apply(mkv(1, 10, 0, 0, 0, 0, 0, 1, 7, 0, 1, 1, 7, 0), "fill_full");
      apply(mkv(1, 10, 0, 0, 0, 0, 1, 10, 4, 0, 0, 1, 0, 0), "fill_flush");
      apply(mkv(0, 10, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0), "fill_after");

      // Reset asserted mid-stream with four writes outstanding.
      for (int r = 11; r <= 14; r++) begin
         apply(mkv(1, r, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, r - 10, 0), $sformatf("mid%0d", r));
      end
      @(negedge clk);
      issue_valid = 1'b1;
      issue_idx_dst = 5'd15;
      query_idx_src_1 = 5'd11;
      query_idx_src_2 = 5'd14;
      rst_n = 1'b0;
      #1;
      chk("mid_rst.inflight_count", 32'(inflight_count), 32'd0);
      chk("mid_rst.src_1_pending", 32'(src_1_pending), 32'd0);
      chk("mid_rst.src_2_pending", 32'(src_2_pending), 32'd0);
      chk("mid_rst.issue_ready", 32'(issue_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("mid_rst.held_inflight", 32'(inflight_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst.resume_inflight", 32'(inflight_count), 32'd1);
      chk("mid_rst.resume_underflow", 32'(underflow_error), 32'd0);
      @(negedge clk);
      clear_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/writeback_scoreboard.md
WRITEBACK_SCOREBOARD -- requirements
Module: writeback_scoreboard

Interface
- REQ-001 SHALL have parameter REGISTER_INDEX_WIDTH, default 5: register index width.
- REQ-002 SHALL have parameter NUM_REGS, default 32: number of architectural registers tracked.
- REQ-003 SHALL have parameter MAX_INFLIGHT, default 7: maximum total outstanding writes, range 1..7.
- REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
- REQ-006 SHALL have port issue_valid, input, 1: decode issues an instruction that writes a register.
- REQ-007 SHALL have port issue_idx_dst, input, REGISTER_INDEX_WIDTH: destination of the issued instruction.
- REQ-008 SHALL have port issue_ready, output, 1: scoreboard can accept the presented issue.
- REQ-009 SHALL have port alu_wb_valid / alu_wb_idx, input, 1 / REGISTER_INDEX_WIDTH: ALU result written back.
- REQ-010 SHALL have port mem_wb_valid / mem_wb_idx, input, 1 / REGISTER_INDEX_WIDTH: load result written back.
- REQ-011 SHALL have port flush, input, 1: discard all outstanding writes.
- REQ-012 SHALL have port query_idx_src_1 / query_idx_src_2, input, REGISTER_INDEX_WIDTH: decode source operands.
- REQ-013 SHALL have port src_1_pending / src_2_pending, output, 1: source has an outstanding write.
- REQ-014 SHALL have port inflight_count, output, 3: total outstanding writes.
- REQ-015 SHALL have port underflow_error, output, 1: sticky flag for writeback with no matching issue.

Function
- REQ-016 SHALL keep one 2-bit saturating pending counter per register, 1..NUM_REGS-1; register 0 is never tracked and always reads not pending.
- REQ-017 SHALL drive issue_ready combinationally: 0 when counter[issue_idx_dst]==3 or inflight_count==MAX_INFLIGHT, else 1; for issue_idx_dst==0 issue_ready depends only on inflight_count.
- REQ-018 SHALL accept an issue when issue_valid & issue_ready & issue_idx_dst!=0; an accepted issue increments counter[issue_idx_dst] and inflight_count at the next edge.
- REQ-019 SHALL ignore issue_valid with issue_idx_dst==0; no counter changes.
- REQ-020 SHALL decrement counter[idx] and inflight_count by one for each of alu_wb_valid and mem_wb_valid whose idx!=0 and whose counter is nonzero.
- REQ-021 SHALL apply the net sum when an issue and writebacks hit the same register in one cycle; e.g. counter 1 + issue + ALU wb -> 1; counter 2 + ALU wb + mem wb, same idx -> 0.
- REQ-022 SHALL, when a writeback targets a register whose counter is already 0 (counting the other same-cycle writeback's decrement first), leave that counter unchanged and set underflow_error at the next edge; writeback to register 0 is ignored without error.
- REQ-023 SHALL drive src_n_pending combinationally from the registered counters as counter[query_idx_src_n]!=0; same-cycle issue or writeback is not bypassed; 0 for index 0.
- REQ-024 SHALL, on flush, clear all counters and inflight_count at the next edge; flush dominates any same-cycle issue and writeback; underflow_error is not cleared by flush.
- REQ-025 SHALL treat index values >= NUM_REGS as register 0.
- REQ-026 SHALL hold underflow_error at 1 until reset.

Reset
- REQ-027 SHALL, while rst_n==0, asynchronously force all counters to 0, inflight_count to 0 and underflow_error to 0; with these values issue_ready==1 and src_n_pending==0.
- REQ-028 SHALL ignore all inputs while rst_n==0, and resume updates on the first rising clk edge with rst_n==1, including when reset asserts mid-operation with writes outstanding.

Verification
- REQ-029 SHALL cover: issue idx 5, next cycle query src_1=5 -> src_1_pending=1, inflight_count=1; alu_wb idx 5 -> next cycle src_1_pending=0, inflight_count=0.
- REQ-030 SHALL cover: three issues to idx 7 -> counter 3, issue_ready=0 for idx 7, issue_ready=1 for idx 8; fourth issue to idx 7 is not accepted, inflight_count stays 3.
- REQ-031 SHALL cover: counter[9]=2, alu_wb and mem_wb both idx 9 plus issue idx 9 in the same cycle -> counter[9]=1, inflight_count drops by 1, no error.
- REQ-032 SHALL cover: mem_wb idx 4 with counter 0 -> underflow_error=1 stays set through a flush; inflight_count unchanged; only rst_n low clears it.
- REQ-033 SHALL cover: fill to MAX_INFLIGHT=7 across distinct regs -> issue_ready=0; flush with simultaneous issue -> all counters 0, inflight_count=0, issue_ready=1.
- REQ-034 SHALL cover: issue idx 0 and query src 0 -> no state change, src_pending=0; rst_n low mid-stream with 4 writes outstanding -> immediate zero state.
